// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous write port,
// a combinational debug port and a wrapping write counter. Optional REGFILE_BYPASS_EN adds write-through.
module reg_file #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [AW-1:0]    dbg_a,
   output logic [WIDTH-1:0] dbg_d,
   output logic [15:0]      wr_cnt
);

   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [15:0]      wr_cnt_q;
   logic [15:0]      wr_cnt_d;
   logic             write_hit_s;

   // Writes to entry 0 are discarded and do not count as committed.
   assign write_hit_s = we && (wa != {AW{1'b0}});

   // Next-state of the committed-write counter; wraps silently.
   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (write_hit_s) begin
         wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
         wr_cnt_d = wr_cnt_q;
      end
   end

   // Storage and counter; reset clears everything without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= {WIDTH{1'b0}};
         end
         wr_cnt_q <= 16'd0;
      end else begin
         if (write_hit_s) begin
            regs_q[wa] <= wd;
         end
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Combinational reads; address 0 and an asserted reset both force zero.
   always_comb begin
      rd1   = {WIDTH{1'b0}};
      rd2   = {WIDTH{1'b0}};
      dbg_d = {WIDTH{1'b0}};
      if (!rst_n) begin
         rd1   = {WIDTH{1'b0}};
         rd2   = {WIDTH{1'b0}};
         dbg_d = {WIDTH{1'b0}};
      end else begin
`ifdef REGFILE_BYPASS_EN
         rd1   = (write_hit_s && (ra1 == wa))   ? wd :
                 (ra1 == {AW{1'b0}})   ? {WIDTH{1'b0}} : regs_q[ra1];
         rd2   = (write_hit_s && (ra2 == wa))   ? wd :
                 (ra2 == {AW{1'b0}})   ? {WIDTH{1'b0}} : regs_q[ra2];
         dbg_d = (write_hit_s && (dbg_a == wa)) ? wd :
                 (dbg_a == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs_q[dbg_a];
`else
         rd1   = (ra1 == {AW{1'b0}})   ? {WIDTH{1'b0}} : regs_q[ra1];
         rd2   = (ra2 == {AW{1'b0}})   ? {WIDTH{1'b0}} : regs_q[ra2];
         dbg_d = (dbg_a == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs_q[dbg_a];
`endif
      end
   end

   assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expectations are queued from a bench-side model
// and compared when the outputs are sampled.
module tb_reg_file;

   localparam int W  = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] ra1, ra2, wa, dbg_a;
   logic [W-1:0]  rd1, rd2, wd, dbg_d;
   logic          we;
   logic [15:0]   wr_cnt;

   typedef struct {
      int          port;   // 0 rd1, 1 rd2, 2 dbg_d, 3 wr_cnt, 4 operand mux
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model [32];
   logic [15:0] cnt_m;
   int          n_checks;
   int          n_pass;
   logic        ctl;
   logic [31:0] imm;

   reg_file #(.WIDTH(W), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .we(we), .wa(wa), .wd(wd),
      .dbg_a(dbg_a), .dbg_d(dbg_d), .wr_cnt(wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
   endtask

   task automatic push_exp(input int port, input string tag, input logic [31:0] v);
      exp_t e;
      e.port = port; e.tag = tag; e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.port)
            0: obs = rd1;
            1: obs = rd2;
            2: obs = dbg_d;
            3: obs = {16'd0, wr_cnt};
            default: obs = ctl ? imm : rd2;
         endcase
         check_val(e.tag, obs, e.val);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
      we = 1'b1; wa = a; wd = d;
      @(posedge clk); #1;
      we = 1'b0;
      if (a != 5'd0) begin
         model[a] = d;
         cnt_m    = cnt_m + 16'd1;
      end
   endtask

   // Pulses reset between clock edges and checks that every output clears immediately.
   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      cnt_m = 16'd0;
      #1;
      push_exp(0, {tag, "_rd1"}, 32'd0);
      push_exp(1, {tag, "_rd2"}, 32'd0);
      push_exp(2, {tag, "_dbg"}, 32'd0);
      push_exp(3, {tag, "_cnt"}, 32'd0);
      drain();
      we = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] v;
      n_checks = 0; n_pass = 0;
      rst_n = 1'b0; we = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0; dbg_a = '0;
      ctl = 1'b0; imm = 32'hFFFF_FFF0;
      cnt_m = 16'd0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;

      // reset state, with non-zero addresses selected
      ra1 = 5'd5; ra2 = 5'd9; dbg_a = 5'd31;
      #2;
      push_exp(0, "por_rd1", 32'd0);
      push_exp(1, "por_rd2", 32'd0);
      push_exp(2, "por_dbg", 32'd0);
      push_exp(3, "por_cnt", 32'd0);
      drain();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: reset clears a written entry before the next edge
      do_write(5'd5, 32'hDEADBEEF);
      ra1 = 5'd5; #1;
      push_exp(0, "pre_rst_r5", model[5]);
      push_exp(3, "pre_rst_cnt", {16'd0, cnt_m});
      drain();
      pulse_reset("rst");
      push_exp(0, "post_rst_r5", 32'd0);
      drain();

      // 2: basic write/read and operand mux ctl=0 path
      do_write(5'd3, 32'hF0F0F0F0);
      do_write(5'd4, 32'h0F0F0F0F);
      ra1 = 5'd3; ra2 = 5'd4; #1;
      push_exp(0, "wr_rd1", 32'hF0F0F0F0);
      push_exp(1, "wr_rd2", 32'h0F0F0F0F);
      push_exp(3, "wr_cnt2", 32'd2);
      push_exp(4, "mux_ctl0", 32'h0F0F0F0F);
      drain();

      // 3: writes to entry 0 are discarded
      do_write(5'd0, 32'hFFFFFFFF);
      ra1 = 5'd0; dbg_a = 5'd0; #1;
      push_exp(0, "x0_rd1", 32'd0);
      push_exp(2, "x0_dbg", 32'd0);
      push_exp(3, "x0_cnt", {16'd0, cnt_m});
      drain();

      // 4: same-cycle read and write of one entry
      do_write(5'd7, 32'h11111111);
      we = 1'b1; wa = 5'd7; wd = 32'h22222222; ra2 = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
      push_exp(1, "rw_before", 32'h22222222);
`else
      push_exp(1, "rw_before", 32'h11111111);
`endif
      drain();
      @(posedge clk); #1;
      we = 1'b0; model[7] = 32'h22222222; cnt_m = cnt_m + 16'd1;
      push_exp(1, "rw_after", model[7]);
      push_exp(3, "rw_cnt", {16'd0, cnt_m});
      drain();

      // reset while a write is pending wins over the write
      ra1 = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
      pulse_reset("rst_mid");
      push_exp(0, "rst_mid_r9", 32'd0);
      push_exp(3, "rst_mid_cnt", 32'd0);
      drain();

      // 5: full sweep across all three read ports
      for (int i = 1; i < 32; i++) begin
         v = 32'(i) * 32'h01010101;
         do_write(AW'(i), v);
      end
      for (int i = 0; i < 32; i++) begin
         ra1 = AW'(i); ra2 = AW'(i); dbg_a = AW'(i); #1;
         push_exp(0, $sformatf("sweep_rd1_%0d", i), model[i]);
         push_exp(1, $sformatf("sweep_rd2_%0d", i), model[i]);
         push_exp(2, $sformatf("sweep_dbg_%0d", i), model[i]);
         drain();
      end
      push_exp(3, "sweep_cnt", 32'd31);
      drain();

      // 6: counter wrap after 65536 committed writes
      pulse_reset("rst_wrap");
      ra1 = 5'd1;
      we = 1'b1; wa = 5'd1;
      for (int i = 0; i < 65536; i++) begin
         wd = 32'(i) ^ 32'h5A000000;
         @(posedge clk); #1;
         model[1] = wd;
         cnt_m    = cnt_m + 16'd1;
         if (i == 65534) begin
            push_exp(3, "cnt_ffff", 32'h0000FFFF);
            drain();
         end
      end
      we = 1'b0; #1;
      push_exp(3, "cnt_wrap", {16'd0, cnt_m});
      push_exp(0, "wrap_r1", model[1]);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Register file for the single-cycle datapath. Sits directly upstream of the 32-bit 2:1 operand mux.
- rd2 feeds the mux data input selected when ctl=0. The other mux input carries the sign-extended immediate.
- rd1 feeds ALU operand A directly.
- Two combinational read ports, one synchronous write port, and a combinational debug read port for bench and board inspection.

Parameters:
- WIDTH, 32, data width of each register and of every data port.
- AW, 5, address width; depth = 2**AW registers (32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ra1  input  AW  read address, port 1 (rs).
- ra2  input  AW  read address, port 2 (rt).
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2; drives the operand mux input selected when ctl=0.
- we  input  1  write enable.
- wa  input  AW  write address (rd/rt).
- wd  input  WIDTH  write data from the writeback mux.
- dbg_a  input  AW  debug read address.
- dbg_d  output  WIDTH  debug read data.
- wr_cnt  output  16  count of committed writes (wraps).

Behaviour:
- Storage: 2**AW entries of WIDTH bits. Entry 0 is hardwired to zero: never written, always reads 0.
- Reset:
  - rst_n low clears all entries to 0 and wr_cnt to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, rd1, rd2 and dbg_d read 0.
  - Deassertion takes effect at the next rising clk edge; the first write is possible on that edge.
- Read:
  - Purely combinational; zero-cycle latency. rd1 = R[ra1], rd2 = R[ra2], dbg_d = R[dbg_a].
  - Any address equal to 0 returns 0.
- Write:
  - On rising clk, when we=1 and wa!=0: R[wa] <= wd, and wr_cnt increments by 1.
  - Writes with wa=0 are discarded and do not increment wr_cnt.
  - we=0: no state change.
- wr_cnt wraps from 16'hFFFF to 16'h0000 with no flag.
- Read/write same address in the same cycle (without the optional feature): the read returns the old value until the edge and the new value after it. No X and no glitch to another entry.
- Both read ports may address the same entry; each returns the same value.
- Reset mid-write: if rst_n falls in the same cycle as we=1, reset wins. The entry and the counter are 0 after reset.
- No X propagation: every output is defined whenever rst_n is low or the inputs are known.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. When we=1, wa!=0 and ra1==wa, rd1 = wd combinationally in the same cycle. The same rule applies to rd2 with ra2, and to dbg_d with dbg_a.
- Not defined: no bypass; reads return only the stored contents, as in the Behaviour section.
- Write timing, the x0 rule and wr_cnt are identical in both builds.

Test Plan:
1. Reset:
   - Stimulus: write R5=32'hDEADBEEF, then pulse rst_n low for 3 ns between clock edges.
   - Response: rd1 (ra1=5) reads 0 immediately, before the next edge; wr_cnt=0.
2. Basic write/read:
   - Stimulus: we=1, wa=3, wd=32'hF0F0F0F0, then wa=4, wd=32'h0F0F0F0F.
   - Response: with ra1=3 and ra2=4 after the edges, rd1=32'hF0F0F0F0, rd2=32'h0F0F0F0F, wr_cnt=2.
   - Downstream check: operand mux with ctl=0 passes 32'h0F0F0F0F.
3. x0 protection:
   - Stimulus: we=1, wa=0, wd=32'hFFFFFFFF over one edge.
   - Response: rd1 (ra1=0) reads 0; wr_cnt unchanged.
4. Same-cycle read/write:
   - Stimulus: R7=32'h11111111, then we=1, wa=7, wd=32'h22222222, ra2=7.
   - Response without REGFILE_BYPASS_EN: rd2=32'h11111111 before the edge, 32'h22222222 after.
   - Response with REGFILE_BYPASS_EN: rd2=32'h22222222 before the edge.
5. Full sweep:
   - Stimulus: write R[i]=i*32'h01010101 for i=1..31, then read all 32 entries via ra1, ra2 and dbg_a.
   - Response: values match on all three ports; R0=0; wr_cnt=31.
6. Counter wrap:
   - Stimulus: force 65536 valid writes to R1.
   - Response: wr_cnt returns to 16'h0000; R1 holds the last written data.
